// File: rtl/unsigned_divide_if.sv
// Start/busy/done handshake bundle for the sequential unsigned divider.
interface unsigned_divide_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/unsigned_divide.sv
// Restoring unsigned divider retiring one quotient bit per clock (WIDTH cycles).
// Divide-by-zero completes in one cycle without entering RUN.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | shifting/subtracting one quotient bit per edge
module unsigned_divide #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    unsigned_divide_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;

    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;

    // One extra bit on the subtraction makes its MSB a clean borrow flag.
    always_comb begin
        shifted = {r[WIDTH-1:0], q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, d};
        borrow  = diff[WIDTH+1];
        r_next  = borrow ? shifted : diff[WIDTH:0];
        q_next  = {q[WIDTH-2:0], ~borrow};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= bus.dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            r     <= '0;
                            q     <= bus.dividend;
                            d     <= bus.divisor;
                            cnt   <= CW'(WIDTH - 1);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient    <= q_next;
                        remainder   <= r_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = done;
    assign bus.quotient    = quotient;
    assign bus.remainder   = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_unsigned_divide.sv
// Directed and random checks of the unsigned divider: results, latency, busy width,
// ignored starts, back-to-back operation, output hold and mid-run reset.
module tb_unsigned_divide;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] prev_q = '0;
    logic [7:0] prev_r = '0;
    logic       prev_z = 1'b0;

    unsigned_divide_if #(.WIDTH(8)) bus ();

    unsigned_divide #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Issues one division, runs it to completion and checks everything about it.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input bit inject);
        int n;
        int busy_cnt;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
        n = 0;
        busy_cnt = 0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cnt++;
            check("hold_quotient", bus.quotient, prev_q);
            check("hold_remainder", bus.remainder, prev_r);
            if (inject && (n == 1 || n == 4)) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd9;
                bus.divisor  = 8'd9;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        check("latency", n, (b == 0) ? 0 : 8);
        check("busy_cycles", busy_cnt, (b == 0) ? 0 : 8);
        check("busy_at_done", bus.busy, 0);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, ez);
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    task automatic expect_done_low();
        @(posedge clk); #1;
        check("done_single_pulse", bus.done, 0);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_dbz", bus.div_by_zero, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        expect_done_low();
        do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        do_div(8'd5, 8'd200, 8'd0, 8'd5, 1'b0, 1'b0);
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
        do_div(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0);
        expect_done_low();

        do_div(8'd37, 8'd0, 8'd255, 8'd37, 1'b1, 1'b0);
        expect_done_low();
        do_div(8'd37, 8'd5, 8'd7, 8'd2, 1'b0, 1'b0);
        expect_done_low();

        do_div(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b1);
        expect_done_low();
        check("busy_after_ignored", bus.busy, 0);

        do_div(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 1'b0);
        do_div(8'd81, 8'd9, 8'd9, 8'd0, 1'b0, 1'b0);
        expect_done_low();

        // Abort 123/4 during its fourth RUN cycle.
        bus.dividend = 8'd123;
        bus.divisor  = 8'd4;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("busy_before_abort", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("abort_no_done", bus.done, 0);
        end
        prev_q = '0;
        prev_r = '0;
        prev_z = 1'b0;
        do_div(8'd123, 8'd4, 8'd30, 8'd3, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom);
            b = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            if (b == 0) do_div(a, b, 8'hFF, a, 1'b1, 1'b0);
            else        do_div(a, b, a / b, a % b, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
